// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the
// fetch (ibus) and load/store (dbus) ports, one access at a time.
module mem_port_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ibus_req,
  input  logic [31:0] ibus_addr,
  output logic [31:0] ibus_data,
  output logic        ibus_ready,
  output logic        ibus_err,
  input  logic        dbus_rd,
  input  logic        dbus_wr,
  input  logic [31:0] dbus_addr,
  input  logic [31:0] dbus_data_wr,
  input  logic [3:0]  dbus_wstrb,
  output logic [31:0] dbus_data_rd,
  output logic        dbus_data_ready,
  output logic        dbus_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_I = 2'd1;
  localparam logic [1:0] S_BUSY_D = 2'd2;

  localparam logic [3:0]  STREAK_LIM = 4'(MAX_D_STREAK);
  localparam logic [15:0] WD_LAST    = 16'(TIMEOUT - 1);
  localparam bit          WD_EN      = (TIMEOUT != 0);

  logic [1:0]  state_q, state_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [3:0]  d_streak_q, d_streak_d;
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        both_q, both_d;

  logic d_req;
  logic grant_d;
  logic grant_i;
  logic wd_hit;
  logic done;
  logic tmo;

  // Low address bits are dropped: the memory is word addressed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ibus_addr[1:0], dbus_addr[1:0]};

  // Arbitration decision and completion detection.
  always_comb begin
    d_req   = dbus_rd | dbus_wr;
    grant_d = d_req &&
              (!ibus_req || (d_streak_q < STREAK_LIM));
    grant_i = ibus_req && !grant_d;
    wd_hit  = WD_EN && (wd_cnt_q == WD_LAST);
    done    = (state_q != S_IDLE) && (mem_ready || wd_hit);
    tmo     = done && !mem_ready;
  end

  // Next-state: latch the granted request, hold it while busy.
  always_comb begin
    state_d     = state_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    d_streak_d  = d_streak_q;
    wd_cnt_d    = wd_cnt_q;
    both_d      = both_q;
    case (state_q)
      S_IDLE: begin
        wd_cnt_d = '0;
        if (grant_d) begin
          state_d    = S_BUSY_D;
          mem_en_d   = 1'b1;
          mem_we_d   = dbus_wr;
          mem_addr_d = {dbus_addr[31:2], 2'b00};
          both_d     = dbus_rd & dbus_wr;
          if (dbus_wr) begin
            mem_wdata_d = dbus_data_wr;
            mem_wstrb_d = dbus_wstrb;
          end else begin
            mem_wstrb_d = 4'b0000;
          end
          if (!ibus_req)
            d_streak_d = '0;
          else if (d_streak_q != 4'hF)
            d_streak_d = d_streak_q + 4'd1;
        end else if (grant_i) begin
          state_d     = S_BUSY_I;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = {ibus_addr[31:2], 2'b00};
          mem_wstrb_d = 4'b0000;
          both_d      = 1'b0;
          d_streak_d  = '0;
        end
      end
      default: begin
        if (done) begin
          state_d  = S_IDLE;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
        end else if (wd_cnt_q != 16'hFFFF) begin
          wd_cnt_d = wd_cnt_q + 16'd1;
        end
      end
    endcase
  end

  // State and memory-side registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      d_streak_q  <= '0;
      wd_cnt_q    <= '0;
      both_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      d_streak_q  <= d_streak_d;
      wd_cnt_q    <= wd_cnt_d;
      both_q      <= both_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign busy      = (state_q != S_IDLE);

  // Completion pulses and read data pass straight through.
  always_comb begin
    ibus_ready      = done && (state_q == S_BUSY_I);
    dbus_data_ready = done && (state_q == S_BUSY_D);
    ibus_err        = ibus_ready && tmo;
    dbus_err        = dbus_data_ready && (tmo || both_q);
    ibus_data       = '0;
    dbus_data_rd    = '0;
    if (ibus_ready && mem_ready)
      ibus_data = mem_rdata;
    if (dbus_data_ready && mem_ready)
      dbus_data_rd = mem_rdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter
// with a small behavioural memory of selectable wait behaviour.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ibus_req = 1'b0;
  logic [31:0] ibus_addr = '0;
  logic [31:0] ibus_data;
  logic        ibus_ready;
  logic        ibus_err;
  logic        dbus_rd = 1'b0;
  logic        dbus_wr = 1'b0;
  logic [31:0] dbus_addr = '0;
  logic [31:0] dbus_data_wr = '0;
  logic [3:0]  dbus_wstrb = '0;
  logic [31:0] dbus_data_rd;
  logic        dbus_data_ready;
  logic        dbus_err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        busy;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
    logic        err;
    logic        chk_data;
  } exp_t;
  exp_t sb[$];

  // mode 0: zero wait, 1: one wait, 2: never, 3: ready on 8th cycle
  int mem_mode = 0;
  int bcyc = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_D_STREAK(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .ibus_req(ibus_req), .ibus_addr(ibus_addr),
    .ibus_data(ibus_data), .ibus_ready(ibus_ready),
    .ibus_err(ibus_err),
    .dbus_rd(dbus_rd), .dbus_wr(dbus_wr),
    .dbus_addr(dbus_addr), .dbus_data_wr(dbus_data_wr),
    .dbus_wstrb(dbus_wstrb), .dbus_data_rd(dbus_data_rd),
    .dbus_data_ready(dbus_data_ready), .dbus_err(dbus_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy)
  );

  function automatic logic [31:0] model(input logic [31:0] a);
    return (a == 32'h100) ? 32'h13 : (a ^ 32'h5A5A_0000);
  endfunction

  always @(posedge clk)
    if (!mem_en || mem_ready) bcyc <= 0;
    else bcyc <= bcyc + 1;

  assign mem_ready = mem_en && ((mem_mode == 0) ||
                     (mem_mode == 1 && bcyc >= 1) ||
                     (mem_mode == 3 && bcyc == 7));
  assign mem_rdata = model(mem_addr);

  task automatic wait_ready(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (ibus_ready || dbus_data_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({mem_en, mem_we, busy, ibus_ready, dbus_data_ready} !== 5'b0)
      $display("FAIL reset_ctl got %b exp 00000",
        {mem_en, mem_we, busy, ibus_ready, dbus_data_ready});
    else n_pass++;
    n_chk++;
    if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0)
      $display("FAIL reset_regs got %h %h %h exp 0",
        mem_addr, mem_wdata, mem_wstrb);
    else n_pass++;
  endtask

  task automatic test_ifetch();
    exp_t e;
    mem_mode = 1;
    @(posedge clk); #1;
    ibus_req = 1'b1;
    ibus_addr = 32'h100;
    sb.push_back('{1'b0, 32'h13, 1'b0, 1'b1});
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({mem_en, mem_we, mem_addr} !== {2'b10, 32'h100})
      $display("FAIL if_grant got en=%b we=%b a=%h exp 1 0 100",
        mem_en, mem_we, mem_addr);
    else n_pass++;
    n_chk++;
    if (ibus_ready !== 1'b0)
      $display("FAIL if_early got %b exp 0", ibus_ready);
    else n_pass++;
    @(negedge clk);
    e = sb.pop_front();
    n_chk++;
    if ({ibus_ready, ibus_err, ibus_data} !== {1'b1, e.err, e.data})
      $display("FAIL if_done got r=%b e=%b d=%h exp 1 %b %h",
        ibus_ready, ibus_err, ibus_data, e.err, e.data);
    else n_pass++;
    @(posedge clk); #1;
    ibus_req = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({busy, mem_en} !== 2'b00)
      $display("FAIL if_idle got %b exp 00", {busy, mem_en});
    else n_pass++;
  endtask

  task automatic test_priority();
    exp_t e;
    bit ok;
    mem_mode = 1;
    @(posedge clk); #1;
    ibus_req = 1'b1;
    ibus_addr = 32'h300;
    dbus_wr = 1'b1;
    dbus_addr = 32'h203;
    dbus_data_wr = 32'hDEADBEEF;
    dbus_wstrb = 4'b0011;
    sb.push_back('{1'b1, 32'h0, 1'b0, 1'b0});
    sb.push_back('{1'b0, model(32'h300), 1'b0, 1'b1});
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({mem_en, mem_we, mem_addr, mem_wstrb, mem_wdata} !==
        {2'b11, 32'h200, 4'b0011, 32'hDEADBEEF})
      $display("FAIL pri_dgrant got %b%b %h %b %h exp 11 200 0011 deadbeef",
        mem_en, mem_we, mem_addr, mem_wstrb, mem_wdata);
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      wait_ready(20, ok);
      n_chk++;
      if (!ok || sb.size() == 0) begin
        $display("FAIL pri_timeout txn %0d got none exp ready", k);
      end else begin
        e = sb.pop_front();
        if (dbus_data_ready !== e.is_d ||
            (e.is_d ? dbus_err : ibus_err) !== e.err ||
            (e.chk_data && ibus_data !== e.data))
          $display("FAIL pri_txn%0d got d=%b ie=%b de=%b id=%h exp d=%b %h",
            k, dbus_data_ready, ibus_err, dbus_err, ibus_data,
            e.is_d, e.data);
        else n_pass++;
      end
      @(posedge clk); #1;
      if (k == 0) dbus_wr = 1'b0;
      else ibus_req = 1'b0;
    end
  endtask

  task automatic test_streak();
    exp_t e;
    int got;
    int last_i;
    mem_mode = 0;
    got = 0;
    last_i = 0;
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 4; j++)
        sb.push_back('{1'b1, model(32'h600), 1'b0, 1'b1});
      sb.push_back('{1'b0, model(32'h700), 1'b0, 1'b1});
    end
    @(posedge clk); #1;
    ibus_req = 1'b1;
    ibus_addr = 32'h700;
    dbus_rd = 1'b1;
    dbus_addr = 32'h600;
    for (int c = 0; c < 40 && got < 10; c++) begin
      @(negedge clk);
      if (ibus_ready || dbus_data_ready) begin
        e = sb.pop_front();
        got++;
        n_chk++;
        if (dbus_data_ready !== e.is_d ||
            (e.is_d ? dbus_data_rd : ibus_data) !== e.data)
          $display("FAIL streak_g%0d got d=%b i=%b exp d=%b data %h",
            got, dbus_data_ready, ibus_ready, e.is_d, e.data);
        else n_pass++;
        if (ibus_ready) begin
          n_chk++;
          if (c - last_i > 10)
            $display("FAIL streak_gap got %0d exp <=10", c - last_i);
          else n_pass++;
          last_i = c;
        end
      end
    end
    n_chk++;
    if (got != 10)
      $display("FAIL streak_count got %0d exp 10", got);
    else n_pass++;
    sb.delete();
    @(posedge clk); #1;
    ibus_req = 1'b0;
    dbus_rd = 1'b0;
  endtask

  task automatic test_watchdog();
    exp_t e;
    bit ok;
    int cnt;
    mem_mode = 2;
    cnt = 0;
    @(posedge clk); #1;
    dbus_rd = 1'b1;
    dbus_addr = 32'h40;
    sb.push_back('{1'b1, 32'h0, 1'b1, 1'b1});
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mem_en) cnt++;
      if (dbus_data_ready) break;
    end
    e = sb.pop_front();
    n_chk++;
    if (cnt != 8)
      $display("FAIL wd_latency got %0d exp 8", cnt);
    else n_pass++;
    n_chk++;
    if ({dbus_data_ready, dbus_err, dbus_data_rd} !==
        {1'b1, e.err, e.data})
      $display("FAIL wd_done got r=%b e=%b d=%h exp 1 %b %h",
        dbus_data_ready, dbus_err, dbus_data_rd, e.err, e.data);
    else n_pass++;
    @(posedge clk); #1;
    dbus_rd = 1'b0;
    mem_mode = 1;
    @(posedge clk); #1;
    dbus_rd = 1'b1;
    dbus_addr = 32'h44;
    sb.push_back('{1'b1, model(32'h44), 1'b0, 1'b1});
    wait_ready(20, ok);
    e = sb.pop_front();
    n_chk++;
    if (!ok || {dbus_data_ready, dbus_err, dbus_data_rd} !==
        {1'b1, e.err, e.data})
      $display("FAIL wd_after got r=%b e=%b d=%h exp 1 0 %h",
        dbus_data_ready, dbus_err, dbus_data_rd, e.data);
    else n_pass++;
    @(posedge clk); #1;
    dbus_rd = 1'b0;
  endtask

  task automatic test_rdwr_both();
    exp_t e;
    bit ok;
    mem_mode = 0;
    @(posedge clk); #1;
    dbus_rd = 1'b1;
    dbus_wr = 1'b1;
    dbus_addr = 32'h80;
    dbus_data_wr = 32'h12345678;
    dbus_wstrb = 4'hF;
    sb.push_back('{1'b1, 32'h0, 1'b1, 1'b0});
    wait_ready(10, ok);
    e = sb.pop_front();
    n_chk++;
    if (!ok || {mem_we, mem_wstrb, mem_wdata} !==
        {1'b1, 4'hF, 32'h12345678})
      $display("FAIL both_write got we=%b s=%h d=%h exp 1 f 12345678",
        mem_we, mem_wstrb, mem_wdata);
    else n_pass++;
    n_chk++;
    if ({dbus_data_ready, dbus_err} !== {1'b1, e.err})
      $display("FAIL both_err got r=%b e=%b exp 1 1",
        dbus_data_ready, dbus_err);
    else n_pass++;
    @(posedge clk); #1;
    dbus_rd = 1'b0;
    dbus_wr = 1'b0;
  endtask

  task automatic test_reset_busy();
    mem_mode = 2;
    @(posedge clk); #1;
    ibus_req = 1'b1;
    ibus_addr = 32'h10;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({busy, mem_en} !== 2'b11)
      $display("FAIL rb_busy got %b exp 11", {busy, mem_en});
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if (ibus_ready !== 1'b0)
      $display("FAIL rb_noready got %b exp 0", ibus_ready);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    ibus_req = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({mem_en, busy, ibus_ready, dut.d_streak_q} !== 7'b0)
      $display("FAIL rb_after got en=%b b=%b r=%b s=%h exp 0",
        mem_en, busy, ibus_ready, dut.d_streak_q);
    else n_pass++;
  endtask

  task automatic test_coincide();
    exp_t e;
    bit ok;
    mem_mode = 3;
    @(posedge clk); #1;
    ibus_req = 1'b1;
    ibus_addr = 32'h500;
    sb.push_back('{1'b0, model(32'h500), 1'b0, 1'b1});
    wait_ready(20, ok);
    e = sb.pop_front();
    n_chk++;
    if (!ok || {ibus_ready, ibus_err, ibus_data} !==
        {1'b1, e.err, e.data})
      $display("FAIL coincide got r=%b e=%b d=%h exp 1 0 %h",
        ibus_ready, ibus_err, ibus_data, e.data);
    else n_pass++;
    @(posedge clk); #1;
    ibus_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ifetch();
    test_priority();
    test_streak();
    test_watchdog();
    test_rdwr_both();
    test_reset_busy();
    test_coincide();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the core's instruction-fetch port (ibus) and load/store port (dbus).
- Sits between the ezpipe core and the memory, and sequences one transaction at a time.
- Data accesses have priority. A streak limit prevents fetch starvation.
- A watchdog terminates hung memory transactions with an error.

Parameters:
- MAX_D_STREAK, 4: consecutive dbus grants allowed while ibus_req is pending before ibus must be granted; legal range 1..15.
- TIMEOUT, 255: cycles in a BUSY state without mem_ready before forced error completion; 0 disables the watchdog; legal range 0..65535.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ibus_req  in  1  fetch request; held until ibus_ready
- ibus_addr  in  32  fetch address; stable while ibus_req is high
- ibus_data  out  32  fetch data; valid when ibus_ready is high
- ibus_ready  out  1  one-cycle completion pulse for ibus
- ibus_err  out  1  qualifies ibus_ready: transaction timed out
- dbus_rd  in  1  load request; held until dbus_data_ready
- dbus_wr  in  1  store request; held until dbus_data_ready
- dbus_addr  in  32  load/store address
- dbus_data_wr  in  32  store data
- dbus_wstrb  in  4  store byte enables
- dbus_data_rd  out  32  load data; valid when dbus_data_ready is high
- dbus_data_ready  out  1  one-cycle completion pulse for dbus
- dbus_err  out  1  qualifies dbus_data_ready: timeout or rd/wr both asserted
- mem_en  out  1  memory access active; held until mem_ready
- mem_we  out  1  write enable; valid with mem_en
- mem_addr  out  32  latched address with bits [1:0] forced to 0
- mem_wdata  out  32  latched store data
- mem_wstrb  out  4  latched strobes; 4'b0000 for reads
- mem_rdata  in  32  memory read data; valid with mem_ready
- mem_ready  in  1  memory completion; ignored when mem_en is low
- busy  out  1  high when state is not IDLE

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. All state and mem_* outputs are registered.
- Reset values: state IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, d_streak=0, wd_cnt=0, busy=0. All ready/err outputs are 0.
- Reset mid-transaction: the in-flight access is abandoned, no ready pulse is issued, and the arbiter is in IDLE the next cycle.
- IDLE arbitration, evaluated each cycle; the chosen request is latched and the state moves to BUSY_x the next cycle with mem_en=1:
  - Only dbus requesting (dbus_rd|dbus_wr): grant D.
  - Only ibus_req: grant I.
  - Both requesting: grant D if d_streak<MAX_D_STREAK, else grant I.
- d_streak rules:
  - On a D grant, increments (saturating at 15) if ibus_req is high; otherwise clears.
  - On an I grant, clears.
- Latch contents:
  - D write (dbus_wr=1): mem_we=1, mem_wdata=dbus_data_wr, mem_wstrb=dbus_wstrb.
  - D read: mem_we=0, mem_wstrb=0.
  - dbus_rd and dbus_wr both high: performed as a write, and dbus_err=1 with its dbus_data_ready.
  - I grant: always a read.
- BUSY_x: mem_* outputs are held constant. wd_cnt clears on entry and increments each cycle.
- Completion in BUSY_x:
  - Trigger: mem_ready=1, or (TIMEOUT≠0 and wd_cnt==TIMEOUT-1).
  - The matching ready output is asserted combinationally in that same cycle.
  - Read data passes through combinationally: ibus_data/dbus_data_rd = mem_rdata, or 0 on timeout.
  - err=1 on timeout.
  - Next cycle: state IDLE, mem_en=0.
  - If mem_ready and timeout coincide, normal completion wins (err=0).
- Minimum latency: request seen in IDLE at cycle N; mem_en=1 at N+1; ready at N+1 if memory is zero-wait. Throughput is one transaction per 2 cycles.
- A requester still asserting its request in the IDLE cycle after its ready pulse is treated as a new request.
- Requests changing while the arbiter is busy are ignored; only the latched copy is used.
- The non-granted port sees ready=0 and data=0.

Test Plan:
- ibus_req=1 alone, addr 0x100, mem_ready one cycle after mem_en, mem_rdata=0x00000013 -> mem_en at N+1 with mem_addr=0x100, mem_we=0; ibus_ready and ibus_data=0x13 at N+2; IDLE at N+3.
- Simultaneous ibus_req and dbus_wr (addr 0x203, data 0xDEADBEEF, wstrb 4'b0011) -> D granted first with mem_addr=0x200, mem_we=1, mem_wstrb=4'b0011; ibus served in the following transaction.
- ibus_req and dbus_rd held continuously, zero-wait memory, MAX_D_STREAK=4 -> grant sequence D,D,D,D,I,D,D,D,D,I; no ibus_ready gap exceeds 10 cycles.
- dbus_rd with mem_ready never asserted, TIMEOUT=8 -> dbus_data_ready=1, dbus_err=1, dbus_data_rd=0 exactly 8 cycles after mem_en rises; next request then proceeds normally.
- dbus_rd=dbus_wr=1 -> write performed; dbus_data_ready with dbus_err=1. Separately, reset asserted in BUSY_I -> no ibus_ready, mem_en=0 and busy=0 the next cycle, d_streak=0.
- mem_ready in the same cycle as the watchdog expiry -> normal completion with err=0 and data=mem_rdata.
